// File: rtl/wb_queue.sv
// Write-back staging queue in front of the register file: buffers execute results,
// drains one per cycle into the RF write port. Optional forwarding enabled by WBQ_FWD_EN.
module wb_queue #(
  parameter int W     = 8,
  parameter int D     = 4,
  parameter int DEPTH = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_kind,
  input  logic [D-1:0] in_dest,
  input  logic [W-1:0] in_data,
  input  logic [D-1:0] in_cdest,
  input  logic         in_carry,
  input  logic         rf_hold,
  output logic         WriteEn,
  output logic         writeEnCarryOut,
  output logic [1:0]   addrFlag,
  output logic [D-1:0] Waddr,
  output logic [D-1:0] waddrCarryOut,
  output logic [W-1:0] DataIn,
  output logic         carryOutData,
  input  logic [D-1:0] rd_addr_a,
  input  logic [D-1:0] rd_addr_acc,
  output logic         fwd_hit_a,
  output logic         fwd_hit_acc,
  output logic [W-1:0] fwd_data_a,
  output logic [W-1:0] fwd_data_acc,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [1:0]   kind;
    logic [D-1:0] dest;
    logic [W-1:0] data;
    logic [D-1:0] cdest;
    logic         carry;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          has_entry, push, pop;

  assign has_entry = (count != '0);
  assign empty     = ~has_entry;
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign pop       = WriteEn;
  assign head      = mem[rd_ptr];

  // Gating with Reset keeps a pending head from being written in the reset cycle.
  assign WriteEn         = has_entry & ~rf_hold & ~Reset;
  assign writeEnCarryOut = WriteEn & (^head.kind);
  assign addrFlag        = has_entry ? head.kind : 2'b00;
  assign Waddr           = (has_entry & head.kind[0]) ? head.dest : '0;
  assign waddrCarryOut   = has_entry ? head.cdest : '0;
  assign DataIn          = has_entry ? head.data : '0;
  assign carryOutData    = has_entry & head.carry;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: entry storage has no reset; occupancy is tracked by count, so stale slots are never observed.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= '{kind: in_kind, dest: in_dest, data: in_data,
                               cdest: in_cdest, carry: in_carry};
  end

`ifdef WBQ_FWD_EN
  // Walks oldest to youngest so the youngest match overwrites; carry beats data within an entry.
  function automatic logic [W:0] lookup(input logic [D-1:0] addr);
    logic [W:0]    res;
    logic [PW-1:0] idx;
    entry_t        e;
    // NOTE: every local gets a value before any conditional path, so no latch is implied.
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      e   = mem[idx];
      if (CW'(i) < count) begin
        if ((^e.kind) && (e.cdest == addr))
          res = {1'b1, {(W-1){1'b0}}, e.carry};
        else if ((e.kind[0] ? e.dest : D'(0)) == addr)
          res = {1'b1, e.data};
      end
    end
    return res;
  endfunction

  assign {fwd_hit_a,   fwd_data_a}   = lookup(rd_addr_a);
  assign {fwd_hit_acc, fwd_data_acc} = lookup(rd_addr_acc);
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr_a, rd_addr_acc};
  assign fwd_hit_a    = 1'b0;
  assign fwd_hit_acc  = 1'b0;
  assign fwd_data_a   = '0;
  assign fwd_data_acc = '0;
`endif

endmodule
